// File: rtl/sw_pkg.sv
// Shared constants and types for the Smith-Waterman Avalon wrapper.
//
// Holds the RS232 slave register map and status bit positions, the default field
// widths of a result, and the state type of the result transmitter. The RX side
// of the wrapper reuses the same register map and status bits.
package sw_pkg;

    // RS232 Avalon-MM slave register map (byte addresses)
    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    // STATUS register bit positions
    localparam int unsigned TX_OK_BIT = 6;
    localparam int unsigned RX_OK_BIT = 7;

    // Result field width defaults
    localparam int unsigned SW_SCORE_W     = 10;
    localparam int unsigned SW_COL_W       = 7;
    localparam int unsigned SW_ROW_W       = 7;
    localparam int unsigned SW_FIELD_BYTES = 8;

    // Representable range of the signed alignment score
    localparam int SW_SCORE_MAX = (1 << (SW_SCORE_W - 1)) - 1;
    localparam int SW_SCORE_MIN = -(1 << (SW_SCORE_W - 1));

    // Result transmitter states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPoll  = 2'd1,
        StWrite = 2'd2
    } sw_tx_state_e;

endpackage

// File: rtl/sw_result_tx.sv
// Smith-Waterman result transmitter.
//
// Accepts one alignment result (score, column, row) per valid/ready handshake and
// sends it as a fixed 4*FIELD_BYTES-byte big-endian frame over an Avalon-MM master
// to the RS232 slave. Each byte is preceded by STATUS polling until TX_OK is set,
// then written to TX.
//
// Frame fields, most significant first: 0, column (zero-extended), row
// (zero-extended), score (sign-extended), each FIELD_BYTES wide.
//
// Ports:
//   avm_clk, avm_rst      clock, asynchronous active-high reset
//   i_valid / o_ready     result handshake; o_ready is high only while idle
//   i_score               signed alignment score
//   i_column, i_row       best-cell coordinates
//   o_done                one-cycle pulse after the last frame byte is accepted
//   avm_address           STATUS_BASE while polling/idle, TX_BASE while writing
//   avm_read, avm_readdata, avm_write, avm_writedata, avm_waitrequest
//                         Avalon-MM master interface, all outputs registered
module sw_result_tx
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_W     = SW_SCORE_W,
    parameter int unsigned COL_W       = SW_COL_W,
    parameter int unsigned ROW_W       = SW_ROW_W,
    parameter int unsigned FIELD_BYTES = SW_FIELD_BYTES
) (
    input  logic               avm_clk,
    input  logic               avm_rst,

    input  logic               i_valid,
    output logic               o_ready,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [COL_W-1:0]   i_column,
    input  logic [ROW_W-1:0]   i_row,
    output logic               o_done,

    output logic [4:0]         avm_address,
    output logic               avm_read,
    input  logic [31:0]        avm_readdata,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic               avm_waitrequest
);

    localparam int unsigned FIELD_W     = 8 * FIELD_BYTES;
    localparam int unsigned FRAME_W     = 4 * FIELD_W;
    localparam int unsigned FRAME_BYTES = 4 * FIELD_BYTES;
    localparam int unsigned CNT_W       = $clog2(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    sw_tx_state_e         state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           addr_q, addr_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic [FRAME_W-1:0]   frame_load;
    logic                 tx_ok;

    // Only TX_OK matters; the remaining STATUS bits are deliberately ignored.
    logic unused_readdata;
    assign unused_readdata = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};

    assign tx_ok = avm_readdata[TX_OK_BIT];

    assign frame_load = {
        {FIELD_W{1'b0}},
        {{(FIELD_W - COL_W){1'b0}}, i_column},
        {{(FIELD_W - ROW_W){1'b0}}, i_row},
        {{(FIELD_W - SCORE_W){i_score[SCORE_W-1]}}, i_score}
    };

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (i_valid) begin
                    frame_d = frame_load;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    addr_d  = STATUS_BASE;
                    state_d = StPoll;
                end
            end

            StPoll: begin
                // TX_OK low: keep read asserted, which re-issues the status read.
                if (!avm_waitrequest && tx_ok) begin
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = TX_BASE;
                    wdata_d = {24'b0, frame_q[FRAME_W-1 -: 8]};
                    state_d = StWrite;
                end
            end

            StWrite: begin
                if (!avm_waitrequest) begin
                    frame_d = frame_q << 8;
                    cnt_d   = cnt_q + CNT_W'(1);
                    write_d = 1'b0;
                    addr_d  = STATUS_BASE;
                    if (cnt_q == LAST_BYTE) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        read_d  = 1'b1;
                        state_d = StPoll;
                    end
                end
            end

            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                addr_d  = STATUS_BASE;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q <= StIdle;
            frame_q <= '0;
            cnt_q   <= '0;
            addr_q  <= STATUS_BASE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign o_ready       = (state_q == StIdle);
    assign o_done        = done_q;
    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;

endmodule
